// File: rtl/axi_tap_stream_arbiter.sv
// Round-robin arbiter that grants one AXI tap at a time, collects a fixed-length
// frame of tagged beats into a small FIFO and replays it on an AXI-Stream master.
module axi_tap_stream_arbiter #(
  parameter int                             DATA_WIDTH        = 128,
  parameter int                             STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0]   TYPE_R            = 3'd0,
  parameter logic [STREAM_TYPE_WIDTH-1:0]   TYPE_W            = 3'd1,
  parameter int                             FRAME_BEATS       = 2,
  parameter int                             FIFO_DEPTH        = 4,
  parameter int                             TIMEOUT           = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_r,
  input  logic                         req_w,
  output logic                         can_forwardR,
  output logic                         can_forwardW,
  input  logic                         r_valid,
  input  logic [DATA_WIDTH-1:0]        r_data,
  input  logic                         w_valid,
  input  logic [DATA_WIDTH-1:0]        w_data,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [STREAM_TYPE_WIDTH-1:0] m_axis_tuser,
  output logic                         timeout_pulse,
  output logic                         drop_pulse,
  output logic                         busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int EW = DATA_WIDTH + STREAM_TYPE_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_r_q, gnt_r_d;
  logic            gnt_w_q, gnt_w_d;
  logic            owner_w_q, owner_w_d;
  logic            prio_w_q, prio_w_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            timeout_pulse_q, timeout_pulse_d;
  logic            drop_pulse_q, drop_pulse_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            push, pop, admit, pick_w, beat_in, beat_last, fifo_nempty;
  logic [CW-1:0]   free_entries;
  logic [EW-1:0]   push_entry, head_entry;

  assign free_entries = CW'(FIFO_DEPTH) - count_q;
  assign admit        = (req_r || req_w) && (free_entries >= CW'(FRAME_BEATS));
  // Contention goes to whichever tap was not served last.
  assign pick_w       = req_w && (!req_r || prio_w_q);
  assign beat_in      = (gnt_r_q && r_valid) || (gnt_w_q && w_valid);
  assign beat_last    = (beat_cnt_q == BW'(FRAME_BEATS - 1));
  assign fifo_nempty  = (count_q != '0);
  assign pop          = fifo_nempty && m_axis_tready;

  assign push_entry   = gnt_r_q ? {beat_last, TYPE_R, r_data} : {beat_last, TYPE_W, w_data};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    gnt_r_d         = gnt_r_q;
    gnt_w_d         = gnt_w_q;
    owner_w_d       = owner_w_q;
    prio_w_d        = prio_w_q;
    beat_cnt_d      = beat_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    timeout_pulse_d = 1'b0;
    push            = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (admit) begin
          state_d    = GRANT;
          gnt_r_d    = !pick_w;
          gnt_w_d    = pick_w;
          owner_w_d  = pick_w;
          beat_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (beat_in) begin
          push       = 1'b1;
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_last) begin
            state_d = RELEASE;
            gnt_r_d = 1'b0;
            gnt_w_d = 1'b0;
          end
        end else if (beat_cnt_q == '0) begin
          // Only an empty frame can time out; a started frame waits for its last beat.
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            state_d         = RELEASE;
            gnt_r_d         = 1'b0;
            gnt_w_d         = 1'b0;
            timeout_pulse_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        prio_w_d = !owner_w_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_pulse_d = (r_valid && !((state_q == GRANT) && gnt_r_q)) ||
                   (w_valid && !((state_q == GRANT) && gnt_w_q));

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      gnt_r_q         <= 1'b0;
      gnt_w_q         <= 1'b0;
      owner_w_q       <= 1'b0;
      prio_w_q        <= 1'b0;
      beat_cnt_q      <= '0;
      tmo_cnt_q       <= '0;
      timeout_pulse_q <= 1'b0;
      drop_pulse_q    <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      gnt_r_q         <= gnt_r_d;
      gnt_w_q         <= gnt_w_d;
      owner_w_q       <= owner_w_d;
      prio_w_q        <= prio_w_d;
      beat_cnt_q      <= beat_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
      drop_pulse_q    <= drop_pulse_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // NOTE: the storage array is not reset; an empty FIFO masks the head to zero instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry    = fifo_nempty ? mem_q[rd_ptr_q] : '0;
  assign m_axis_tvalid = fifo_nempty;
  assign m_axis_tdata  = head_entry[DATA_WIDTH-1:0];
  assign m_axis_tuser  = head_entry[DATA_WIDTH +: STREAM_TYPE_WIDTH];
  assign m_axis_tlast  = head_entry[EW-1];

  assign can_forwardR  = gnt_r_q;
  assign can_forwardW  = gnt_w_q;
  assign timeout_pulse = timeout_pulse_q;
  assign drop_pulse    = drop_pulse_q;
  assign busy          = (state_q != IDLE) || fifo_nempty;

endmodule

// File: tb/tb_axi_tap_stream_arbiter.sv
// Directed bench for axi_tap_stream_arbiter: taps are driven step by step and a
// scoreboard queue holds every beat the stream is expected to deliver, in order.
module tb_axi_tap_stream_arbiter;

  localparam int         DW     = 128;
  localparam int         SW     = 3;
  localparam logic [2:0] T_R    = 3'd0;
  localparam logic [2:0] T_W    = 3'd1;
  localparam int         FB     = 2;
  localparam int         DEPTH  = 4;
  localparam int         TMO    = 255;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_r, req_w;
  logic          can_forwardR, can_forwardW;
  logic          r_valid, w_valid;
  logic [DW-1:0] r_data, w_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [SW-1:0] m_axis_tuser;
  logic          timeout_pulse, drop_pulse, busy;

  int            n_checks = 0;
  int            n_fail   = 0;
  beat_t         sb[$];

  logic          held_vld = 1'b0;
  logic [DW-1:0] held_data;
  logic [SW-1:0] held_user;
  logic          held_last;
  beat_t         exp_b;

  axi_tap_stream_arbiter #(
    .DATA_WIDTH(DW), .STREAM_TYPE_WIDTH(SW), .TYPE_R(T_R), .TYPE_W(T_W),
    .FRAME_BEATS(FB), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_r(req_r), .req_w(req_w),
    .can_forwardR(can_forwardR), .can_forwardW(can_forwardW),
    .r_valid(r_valid), .r_data(r_data), .w_valid(w_valid), .w_data(w_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .timeout_pulse(timeout_pulse), .drop_pulse(drop_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: pops on handshakes and checks that stalled outputs do not move.
  always @(negedge clk) begin
    if (reset) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata",  m_axis_tdata,  held_data);
        check("hold_tuser",  m_axis_tuser,  held_user);
        check("hold_tlast",  m_axis_tlast,  held_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("sb_has_entry", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          check("stream_tdata", m_axis_tdata, exp_b.data);
          check("stream_tuser", m_axis_tuser, exp_b.user);
          check("stream_tlast", m_axis_tlast, exp_b.last);
        end
      end
      held_vld  = m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      held_user = m_axis_tuser;
      held_last = m_axis_tlast;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic [SW-1:0] u, input logic l);
    beat_t b;
    b.data = d;
    b.user = u;
    b.last = l;
    sb.push_back(b);
  endtask

  task automatic check_reset_outputs();
    check("rst_can_forwardR",  can_forwardR,  0);
    check("rst_can_forwardW",  can_forwardW,  0);
    check("rst_tvalid",        m_axis_tvalid, 0);
    check("rst_tdata",         m_axis_tdata,  0);
    check("rst_tlast",         m_axis_tlast,  0);
    check("rst_tuser",         m_axis_tuser,  0);
    check("rst_timeout_pulse", timeout_pulse, 0);
    check("rst_drop_pulse",    drop_pulse,    0);
    check("rst_busy",          busy,          0);
  endtask

  task automatic wait_grant(input bit want_w);
    for (int i = 0; i < 600; i++) begin
      if (can_forwardR || can_forwardW) break;
      step();
    end
    check("grant_seen", (can_forwardR || can_forwardW), 1);
    check("grant_owner_w", can_forwardW, want_w);
    check("grant_owner_r", can_forwardR, !want_w);
  endtask

  task automatic send_frame(input bit is_w, input logic [DW-1:0] base);
    for (int i = 0; i < FB; i++) begin
      check("frame_grant_held", is_w ? can_forwardW : can_forwardR, 1);
      if (is_w) begin
        w_valid = 1'b1;
        w_data  = base + DW'(i);
      end else begin
        r_valid = 1'b1;
        r_data  = base + DW'(i);
      end
      expect_beat(base + DW'(i), is_w ? T_W : T_R, (i == FB - 1));
      step();
    end
    r_valid = 1'b0;
    w_valid = 1'b0;
    check("frame_grant_dropped", {can_forwardR, can_forwardW}, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !m_axis_tvalid) break;
      step();
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_tvalid", m_axis_tvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;

    reset = 1'b1;
    req_r = 1'b0; req_w = 1'b0;
    r_valid = 1'b0; w_valid = 1'b0;
    r_data = '0; w_data = '0;
    m_axis_tready = 1'b1;
    repeat (3) step();
    check_reset_outputs();
    reset = 1'b0;
    step();

    // Single read frame with one-cycle stream latency.
    req_r = 1'b1;
    wait_grant(1'b0);
    r_valid = 1'b1; r_data = 'hA; expect_beat('hA, T_R, 1'b0);
    step();
    check("lat_tvalid", m_axis_tvalid, 1);
    check("lat_tdata_a", m_axis_tdata, 'hA);
    check("lat_tlast_a", m_axis_tlast, 0);
    check("lat_grant_r", can_forwardR, 1);
    r_data = 'hB; expect_beat('hB, T_R, 1'b1);
    step();
    r_valid = 1'b0; req_r = 1'b0;
    check("rel_grant_r_low", can_forwardR, 0);
    check("rel_busy", busy, 1);
    check("rel_tdata_b", m_axis_tdata, 'hB);
    check("rel_tlast_b", m_axis_tlast, 1);
    check("rel_tuser_b", m_axis_tuser, T_R);
    step();
    check("idle_busy", busy, 0);
    step();
    check("idle_no_grant", {can_forwardR, can_forwardW}, 0);
    drain();

    // Contention after reset: pointer favours R, then strict alternation.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_r = 1'b1; req_w = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(k[0]);
      send_frame(k[0], DW'(32'h200 + k * 16));
    end
    req_r = 1'b0; req_w = 1'b0;
    drain();

    // Backpressure: two frames fill the FIFO, the third waits for two pops.
    m_axis_tready = 1'b0;
    req_r = 1'b1;
    wait_grant(1'b0);
    send_frame(1'b0, 'h300);
    wait_grant(1'b0);
    send_frame(1'b0, 'h310);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | can_forwardR | can_forwardW;
    end
    check("bp_full_no_grant", seen, 0);
    check("bp_head", m_axis_tdata, 'h300);
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | can_forwardR | can_forwardW;
    end
    check("bp_one_free_no_grant", seen, 0);
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    wait_grant(1'b0);
    send_frame(1'b0, 'h320);
    req_r = 1'b0;
    m_axis_tready = 1'b1;
    drain();

    // Timeout on an empty write grant, then a normal write frame.
    req_w = 1'b1;
    wait_grant(1'b1);
    n = 0;
    while (can_forwardW && n < 400) begin
      n++;
      step();
    end
    req_w = 1'b0;
    check("tmo_grant_cycles", n, TMO);
    check("tmo_pulse_high", timeout_pulse, 1);
    check("tmo_nothing_streamed", m_axis_tvalid, 0);
    step();
    check("tmo_pulse_one_cycle", timeout_pulse, 0);
    req_w = 1'b1;
    wait_grant(1'b1);
    send_frame(1'b1, 'h400);
    req_w = 1'b0;
    drain();

    // Stray read beat during a write grant, then a stray beat in IDLE.
    req_w = 1'b1;
    wait_grant(1'b1);
    w_valid = 1'b1; w_data = 'h500; r_valid = 1'b1; r_data = 'hDEAD;
    expect_beat('h500, T_W, 1'b0);
    step();
    check("stray_drop_pulse", drop_pulse, 1);
    r_valid = 1'b0;
    w_data = 'h501;
    expect_beat('h501, T_W, 1'b1);
    step();
    w_valid = 1'b0; req_w = 1'b0;
    check("stray_drop_clear", drop_pulse, 0);
    check("stray_grant_dropped", can_forwardW, 0);
    step();
    step();
    r_valid = 1'b1; r_data = 'hBAD;
    step();
    r_valid = 1'b0;
    check("idle_stray_drop", drop_pulse, 1);
    drain();

    // Reset after the first beat of a frame, then a clean frame.
    m_axis_tready = 1'b0;
    req_r = 1'b1;
    wait_grant(1'b0);
    r_valid = 1'b1; r_data = 'h600;
    step();
    check("midframe_beat_queued", m_axis_tvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    sb.delete();
    r_valid = 1'b0; req_r = 1'b0;
    step();
    reset = 1'b0;
    m_axis_tready = 1'b1;
    req_r = 1'b1;
    wait_grant(1'b0);
    send_frame(1'b0, 'h700);
    req_r = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
